stim_gen: RTL and testbench

Self-checking traffic source that sits directly upstream of `dut` inside `top` and drives its input stream. On `start` it emits `NUM_TXNS` pseudo-random data beats over a valid/ready interface, with LFSR-controlled idle gaps between beats. A stall watchdog fills the timeout slot in `top`. It reports `done` or `timeout` to the testbench harness.

---
 rtl/stim_gen_pkg.sv | 27 ++
 rtl/stim_gen_lfsr32.sv | 41 ++++
 rtl/stim_gen.sv | 188 ++++++++++++++++++
 tb/tb_stim_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_gen_pkg.sv
// Shared types and LFSR step function for the stimulus generator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_e    - generator FSM states
//   LFSR_POLY  - Galois feedback mask for x^32+x^22+x^2+x+1
//   lfsr_next  - one right-shifting Galois LFSR step
package stim_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND    = 3'd1,
      GAP     = 3'd2,
      DONE    = 3'd3,
      TIMEOUT = 3'd4
   } state_e;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   // Right-shift Galois form: the bit shifted out of bit 0 is fed back
   // through the tap mask.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
   endfunction

endpackage

// File: rtl/stim_gen_lfsr32.sv
// 32-bit Galois LFSR register that holds its state and steps on request.
// Latency: q reflects one step on the clock edge after adv is high.
// Backpressure: none; the state holds whenever adv is low.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset; loads seed
//   seed - reset value, must be nonzero
//   adv  - step the LFSR by one position
//   q    - current LFSR state
module lfsr32
   import stim_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] seed,
   input  logic        adv,
   output logic [31:0] q
);

   logic [31:0] lfsr_q;
   logic [31:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (adv) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/stim_gen.sv
// Pseudo-random beat source with LFSR-driven idle gaps and a stall watchdog.
// Latency: out_valid rises the cycle after start is sampled; all outputs are registered.
// Backpressure: holds data/last while out_ready is low; TIMEOUT_CYC stalled cycles abort the run.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   start         - begin a run (only honoured in IDLE)
//   out_valid/out_ready/out_data/out_last - output beat stream
//   busy          - run in progress (SEND or GAP)
//   done, timeout - sticky completion / watchdog flags, cleared by rst only
//   txn_cnt       - number of accepted beats
module stim_gen
   import stim_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter int          NUM_TXNS    = 16,
   parameter logic [31:0] SEED        = 32'hACE1_2345,
   parameter logic [1:0]  GAP_MASK    = 2'b11,
   parameter int          TIMEOUT_CYC = 1000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATA_W-1:0]                 out_data,
   output logic                              out_last,
   output logic                              busy,
   output logic                              done,
   output logic                              timeout,
   output logic [$clog2(NUM_TXNS+1)-1:0]     txn_cnt
);

   localparam int CNT_W   = $clog2(NUM_TXNS + 1);
   localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(NUM_TXNS - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

   state_e state_q, state_d;

   logic [31:0]        lfsr_q;
   logic [31:0]        lfsr_nxt;
   logic [31:0]        lfsr_d;
   logic               hs;
   logic [1:0]         gap_len;
   logic               last_beat;
   logic               stall_hit;

   logic [CNT_W-1:0]   txn_cnt_q,   txn_cnt_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [1:0]         gap_cnt_q,   gap_cnt_d;

   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q,  out_data_d;
   logic               out_last_q,  out_last_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic               timeout_q,   timeout_d;

   // The LFSR steps only on an accepted beat, so the beat sequence is a
   // function of the seed alone, independent of backpressure timing.
   lfsr32 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (SEED),
      .adv  (hs),
      .q    (lfsr_q)
   );

   // out_valid_q is high exactly in SEND, so it doubles as the state qualifier.
   assign hs        = out_valid_q && out_ready;
   assign lfsr_nxt  = lfsr_next(lfsr_q);
   assign lfsr_d    = hs ? lfsr_nxt : lfsr_q;
   assign gap_len   = lfsr_nxt[31:30] & GAP_MASK;
   assign last_beat = (txn_cnt_q == LAST_IDX);
   assign stall_hit = (stall_cnt_q == STALL_LAST);

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SEND;
            end
         end
         SEND: begin
            // A handshake takes priority over the watchdog threshold.
            if (hs) begin
               if (last_beat) begin
                  state_d = DONE;
               end else if (gap_len != 2'd0) begin
                  state_d = GAP;
               end
            end else if (stall_hit) begin
               state_d = TIMEOUT;
            end
         end
         GAP: begin
            if (gap_cnt_q == 2'd1) begin
               state_d = SEND;
            end
         end
         DONE:    state_d = DONE;
         TIMEOUT: state_d = TIMEOUT;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Counters and registered-output next values
   // ---------------------------------------------------------------
   always_comb begin
      txn_cnt_d   = txn_cnt_q;
      stall_cnt_d = '0;
      gap_cnt_d   = gap_cnt_q;

      if (hs) begin
         txn_cnt_d = txn_cnt_q + CNT_W'(1);
      end

      // Counts consecutive un-accepted cycles in SEND; any other cycle clears it.
      if ((state_q == SEND) && !hs) begin
         stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end

      if ((state_q == SEND) && hs) begin
         gap_cnt_d = gap_len;
      end else if (state_q == GAP) begin
         gap_cnt_d = gap_cnt_q - 2'd1;
      end

      // Outputs are computed from the next state so they line up with it.
      out_valid_d = (state_d == SEND);
      out_data_d  = out_valid_d ? lfsr_d[DATA_W-1:0] : '0;
      out_last_d  = out_valid_d && (txn_cnt_d == LAST_IDX);
      busy_d      = (state_d == SEND) || (state_d == GAP);
      done_d      = (state_d == DONE);
      timeout_d   = (state_d == TIMEOUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         txn_cnt_q   <= '0;
         stall_cnt_q <= '0;
         gap_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         txn_cnt_q   <= txn_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_stim_gen.sv
// Bench for stim_gen: two instances (short gap-free run with a tight watchdog,
// and a 16-beat gapped run under random backpressure) checked against a
// cycle-level reference built from the LFSR beat table.
module tb_stim_gen;

   localparam logic [31:0] SEED  = 32'hACE1_2345;
   localparam logic [31:0] POLY  = 32'h8020_0003;

   logic clk;

   // Instance A: NUM_TXNS=4, GAP_MASK=0, TIMEOUT_CYC=8, DATA_W=32
   logic        a_rst, a_start, a_rdy;
   logic        a_vld, a_last, a_busy, a_done, a_to;
   logic [31:0] a_dat;
   logic [2:0]  a_txn;

   // Instance B: NUM_TXNS=16, GAP_MASK=3, TIMEOUT_CYC=1000, DATA_W=16
   logic        b_rst, b_start, b_rdy;
   logic        b_vld, b_last, b_busy, b_done, b_to;
   logic [15:0] b_dat;
   logic [4:0]  b_txn;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] beats [0:16];

   stim_gen #(
      .DATA_W(32), .NUM_TXNS(4), .SEED(SEED), .GAP_MASK(2'b00), .TIMEOUT_CYC(8)
   ) u_a (
      .clk(clk), .rst(a_rst), .start(a_start),
      .out_valid(a_vld), .out_ready(a_rdy), .out_data(a_dat), .out_last(a_last),
      .busy(a_busy), .done(a_done), .timeout(a_to), .txn_cnt(a_txn)
   );

   stim_gen #(
      .DATA_W(16), .NUM_TXNS(16), .SEED(SEED), .GAP_MASK(2'b11), .TIMEOUT_CYC(1000)
   ) u_b (
      .clk(clk), .rst(b_rst), .start(b_start),
      .out_valid(b_vld), .out_ready(b_rdy), .out_data(b_dat), .out_last(b_last),
      .busy(b_busy), .done(b_done), .timeout(b_to), .txn_cnt(b_txn)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL global_time_limit: simulation still running at %0t, required to have finished", $time);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Polynomial view of the LFSR: state is a GF(2) element; one step divides by x
   // modulo x^32+x^22+x^2+x+1 (i.e. odd values get the reduction mask folded in).
   function automatic logic [31:0] model_step(input logic [31:0] s);
      logic [31:0] r;
      r = s >> 1;
      if (s % 2 == 1) r = r ^ POLY;
      return r;
   endfunction

   task automatic start_a();
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
   endtask

   task automatic check_a_zero(input string tag);
      check({tag, "_vld"},  a_vld,  0);
      check({tag, "_dat"},  a_dat,  0);
      check({tag, "_last"}, a_last, 0);
      check({tag, "_busy"}, a_busy, 0);
      check({tag, "_done"}, a_done, 0);
      check({tag, "_to"},   a_to,   0);
      check({tag, "_txn"},  a_txn,  0);
   endtask

   initial begin
      int idx, gap, cyc, hs_obs;
      logic rdy, exp_v;

      beats[0] = SEED;
      for (int i = 1; i <= 16; i++) beats[i] = model_step(beats[i-1]);

      a_rst = 1'b1; a_start = 1'b0; a_rdy = 1'b0;
      b_rst = 1'b1; b_start = 1'b0; b_rdy = 1'b0;
      repeat (3) @(negedge clk);

      // ---------------- Reset state ----------------
      check_a_zero("a_reset");
      a_rst = 1'b0;
      @(negedge clk);
      check("a_idle_vld", a_vld, 0);
      check("a_idle_busy", a_busy, 0);

      // ---------------- Back-to-back run ----------------
      a_rdy = 1'b1;
      start_a();
      for (int i = 0; i < 4; i++) begin
         check("a_b2b_vld",  a_vld,  1);
         check("a_b2b_dat",  a_dat,  beats[i]);
         check("a_b2b_last", a_last, (i == 3));
         check("a_b2b_txn",  a_txn,  i);
         check("a_b2b_busy", a_busy, 1);
         @(negedge clk);
      end
      check("a_b2b_done", a_done, 1);
      check("a_b2b_txn4", a_txn,  4);
      check("a_b2b_vld0", a_vld,  0);
      check("a_b2b_busy0", a_busy, 0);
      check("a_b2b_last0", a_last, 0);

      // start pulsed in DONE: no effect
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      repeat (3) begin
         check("a_done_start_done", a_done, 1);
         check("a_done_start_vld",  a_vld,  0);
         check("a_done_start_txn",  a_txn,  4);
         @(negedge clk);
      end

      // ---------------- Backpressure and watchdog boundary ----------------
      a_rst = 1'b1;
      @(negedge clk);
      a_rst = 1'b0;
      a_rdy = 1'b1;
      start_a();
      check("a_bp_dat0", a_dat, beats[0]);
      @(negedge clk);
      a_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         a_start = (k == 2);        // start in SEND is ignored
         check("a_bp_vld", a_vld, 1);
         check("a_bp_dat", a_dat, beats[1]);
         check("a_bp_txn", a_txn, 1);
         @(negedge clk);
      end
      a_start = 1'b0;
      check("a_bp_hold_dat", a_dat, beats[1]);
      a_rdy = 1'b1;
      @(negedge clk);
      check("a_bp_dat2", a_dat, beats[2]);
      check("a_bp_txn2", a_txn, 2);
      a_rdy = 1'b0;
      repeat (7) begin
         check("a_thr_vld", a_vld, 1);
         check("a_thr_dat", a_dat, beats[2]);
         @(negedge clk);
      end
      // accepted on the cycle that would otherwise trip the watchdog
      a_rdy = 1'b1;
      check("a_thr_to_pre", a_to, 0);
      @(negedge clk);
      check("a_thr_to",   a_to,   0);
      check("a_thr_dat3", a_dat,  beats[3]);
      check("a_thr_last", a_last, 1);
      check("a_thr_txn3", a_txn,  3);
      @(negedge clk);
      check("a_bp_done", a_done, 1);
      check("a_bp_txn4", a_txn,  4);
      check("a_bp_to",   a_to,   0);

      // ---------------- Timeout ----------------
      a_rst = 1'b1;
      @(negedge clk);
      a_rst = 1'b0;
      a_rdy = 1'b0;
      start_a();
      for (int k = 0; k <= 8; k++) begin
         check("a_to_flag", a_to,  (k == 8));
         check("a_to_vld",  a_vld, (k < 8));
         if (k < 8) @(negedge clk);
      end
      check("a_to_done", a_done, 0);
      check("a_to_txn",  a_txn,  0);
      check("a_to_busy", a_busy, 0);
      a_rdy = 1'b1;
      repeat (2) @(negedge clk);
      check("a_to_hold", a_to,   1);
      check("a_to_vld_hold", a_vld, 0);
      check("a_to_txn_hold", a_txn, 0);

      // ---------------- Reset mid-run ----------------
      a_rst = 1'b1;
      @(negedge clk);
      a_rst = 1'b0;
      a_rdy = 1'b1;
      start_a();
      @(negedge clk);
      @(negedge clk);
      check("a_mid_txn2", a_txn, 2);
      a_rst = 1'b1;
      @(negedge clk);
      check_a_zero("a_mid_rst");
      a_rst = 1'b0;
      start_a();
      check("a_rerun_vld", a_vld, 1);
      check("a_rerun_dat", a_dat, beats[0]);
      check("a_rerun_txn", a_txn, 0);

      // ---------------- Gapped run, random backpressure ----------------
      b_rst = 1'b0;
      @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      idx = 0; gap = 0; cyc = 0; hs_obs = 0;
      while (idx < 16 && cyc < 2000) begin
         exp_v = (gap == 0);
         check("b_vld",  b_vld,  exp_v);
         check("b_busy", b_busy, 1);
         if (exp_v) begin
            check("b_dat",  b_dat,  beats[idx][15:0]);
            check("b_last", b_last, (idx == 15));
            check("b_txn",  b_txn,  idx);
         end
         rdy = ($urandom_range(0, 3) != 0);
         b_rdy = rdy;
         if (b_vld && rdy) hs_obs++;
         if (exp_v) begin
            if (rdy) begin
               idx++;
               if (idx < 16) gap = int'(beats[idx][31:30]);
            end
         end else begin
            gap--;
         end
         @(negedge clk);
         cyc++;
      end
      check("b_run_bound", (idx == 16), 1);
      check("b_done",   b_done, 1);
      check("b_txn16",  b_txn,  16);
      check("b_vld_end", b_vld, 0);
      check("b_hs_cnt", hs_obs, 16);
      check("b_to",     b_to,   0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
